spi_read_segmenter: RTL and testbench
=====================================

// Module: spi_read_segmenter
// PURPOSE
// - Upstream request stage for the SPI flash read engine. Accepts one host read request (start, end, mode).
// - Splits the request into segments that never cross a die boundary and never exceed MAX_BURST bytes.
// - Drives each segment to the read engine's start_flag/start_addr/end_addr/mode/switch_die_need inputs.
// - Sequences segments using the engine's busy/completed handshake, then reports done or error.
// PARAMETERS
// - DIE_LOG2     25     log2 of die size in bytes (die boundary every 0x0200_0000)
// - MAX_BURST    256    max bytes per segment; power of two, >=1
// - GAP_CYCLES   4      idle cycles between segments, counted after completed=0 and busy=0
// - TIMEOUT      65535  max cycles in WAIT_DONE before abort
// PORTS
// - iCLK_25M_CKMNG_MAIN_PLD     in   1   clock, 25 MHz
// - PWRGD_P1V2_MAX10_AUX_PLD_R  in   1   reset; synchronous, active-low
// - req_valid   in   1   host request valid
// - req_ready   out  1   high in IDLE only; transfer occurs when req_valid & req_ready
// - req_start   in   32  first byte address (inclusive)
// - req_end     in   32  last byte address (inclusive)
// - req_mode    in   2   00 std, 01 dual, 10 quad, 11 illegal
// - start_flag  out  1   to engine; level, held until completed sampled high
// - start_addr  out  32  segment first address; stable while start_flag=1
// - end_addr    out  32  segment last address; stable while start_flag=1
// - mode        out  2   segment mode (= req_mode)
// - switch_die_need out 1 high with start_flag when segment die != currently selected die
// - busy        in   1   engine busy
// - completed   in   1   engine segment complete
// - done        out  1   one-cycle pulse: all segments complete
// - err         out  1   one-cycle pulse: illegal request or timeout
// - seg_count   out  16  segments issued for the current or last request
// BEHAVIOUR
// - Reset (sampled low at an edge): state=IDLE.
//   - All outputs 0, except req_ready=1 on the first cycle after reset release.
//   - cur_die=0, seg_count=0.
//   - Reset mid-operation drops start_flag at that edge. No done/err is issued.
// - FSM states: IDLE, CALC, ISSUE, WAIT_DONE, GAP, DONE.
// - IDLE: on accept, latch start/end/mode, clear seg_count, then check legality:
//   - req_end < req_start, or req_mode=11: err pulse next cycle, return to IDLE, no segment issued.
//   - Otherwise: cur=req_start, go to CALC.
// - CALC (1 cycle) computes the segment end:
//   - die_last  = {cur[31:DIE_LOG2], all ones}
//   - burst_last = cur | (MAX_BURST-1)   (burst aligned to MAX_BURST)
//   - seg_end = min(req_end, die_last, burst_last); all 32-bit unsigned.
//   - Register start_addr=cur, end_addr=seg_end, mode.
//   - switch_die_need = (cur[31:DIE_LOG2] != cur_die).
// - ISSUE: assert start_flag, seg_count+=1, cur_die=cur[31:DIE_LOG2], go to WAIT_DONE.
//   - Latency from accept to start_flag rising: 2 cycles (for legal requests).
// - WAIT_DONE: start_flag held high.
//   - On completed=1: drop start_flag next edge and go to GAP.
//   - Timeout counter reaching TIMEOUT: drop start_flag, err pulse, go to IDLE.
// - GAP: wait for completed=0 and busy=0, then count GAP_CYCLES.
//   - If seg_end == req_end: go to DONE.
//   - Else cur = seg_end+1 and go to CALC.
//   - Termination is by equality, never cur>end, so req_end=0xFFFF_FFFF causes no wrap issue.
// - DONE: done pulse for 1 cycle, go to IDLE.
// - switch_die_need deasserts together with start_flag.
// - req_valid outside IDLE is ignored; the request is not latched.
// - busy/completed high while in IDLE are ignored.
// TESTING
// - 0x0000_0000..0x0000_000F, mode 00:
//   - Expect 1 segment: start_addr 0, end_addr 0xF, switch_die_need 0, seg_count 1, done pulse.
// - 0x0000_0100..0x0000_02FF, mode 10:
//   - Expect 2 segments: 0x100-0x1FF and 0x200-0x2FF, both mode 10, seg_count 2.
// - 0x01FF_FFF0..0x0200_0010, mode 00:
//   - Expect segments 0x01FF_FFF0-0x01FF_FFFF (switch_die_need 0), then 0x0200_0000-0x0200_0010 (switch_die_need 1).
// - end < start (0x20..0x10), then mode 11:
//   - Each produces an err pulse, start_flag stays 0, req_ready returns 1.
// - Engine model never asserts completed, TIMEOUT=100:
//   - start_flag falls and err pulses exactly 100 cycles after start_flag rises.
// - Reset asserted in WAIT_DONE:
//   - start_flag=0 at the next edge, no done, and a new request is accepted cleanly afterwards.

Source files
------------

// File: rtl/spi_read_segmenter.sv
// spi_read_segmenter
//   Front end of the SPI flash read engine. Takes one host read request
//   (inclusive start/end address and bus mode) and splits it into segments
//   that never cross a die boundary and never exceed MAX_BURST bytes. Each
//   segment is handed to the engine with start_flag/start_addr/end_addr/mode
//   and switch_die_need, and sequenced with the engine's busy/completed
//   handshake. The request ends with a one-cycle done or err pulse.
//
// Ports
//   iCLK_25M_CKMNG_MAIN_PLD      clock (25 MHz)
//   PWRGD_P1V2_MAX10_AUX_PLD_R   synchronous active-low reset
//   req_valid/req_ready          host handshake, ready only in IDLE
//   req_start/req_end/req_mode   inclusive byte range and mode (11 illegal)
//   start_flag                   level request to the engine, held until completed
//   start_addr/end_addr/mode     current segment, stable while start_flag=1
//   switch_die_need              segment lives on a different die than the last one
//   busy/completed               engine status
//   done/err                     one-cycle completion / failure pulses
//   seg_count                    segments issued for the current or last request
module spi_read_segmenter #(
  parameter int DIE_LOG2   = 25,
  parameter int MAX_BURST  = 256,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic        iCLK_25M_CKMNG_MAIN_PLD,
  input  logic        PWRGD_P1V2_MAX10_AUX_PLD_R,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_start,
  input  logic [31:0] req_end,
  input  logic [1:0]  req_mode,
  output logic        start_flag,
  output logic [31:0] start_addr,
  output logic [31:0] end_addr,
  output logic [1:0]  mode,
  output logic        switch_die_need,
  input  logic        busy,
  input  logic        completed,
  output logic        done,
  output logic        err,
  output logic [15:0] seg_count
);

  localparam int          BURST_LOG2   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 0;
  localparam logic [31:0] GAP_LIMIT    = GAP_CYCLES;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 1;

  typedef enum logic [2:0] {
    IDLE, CALC, ISSUE, WAIT_DONE, GAP, DONE
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]         cur_reg;
  logic [31:0]         req_end_reg;
  logic [1:0]          req_mode_reg;
  logic [31-DIE_LOG2:0] cur_die_reg;
  logic                sw_pending_reg;
  logic [31:0]         start_addr_reg, end_addr_reg;
  logic [1:0]          mode_reg;
  logic                start_flag_reg, switch_reg, done_reg, err_reg;
  logic [15:0]         seg_count_reg;
  logic [31:0]         wait_cnt_reg, gap_cnt_reg;

  // Low-bit masks: OR-ing them into cur gives the last byte of the die and
  // of the aligned burst that cur sits in.
  logic [31:0] die_mask, burst_mask;
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_mask
      assign die_mask[gi]   = (gi < DIE_LOG2);
      assign burst_mask[gi] = (gi < BURST_LOG2);
    end
  endgenerate

  logic [31:0] die_last, burst_last, seg_end;
  logic        accept, illegal, engine_idle, gap_done, timed_out, last_seg;

  always_comb begin
    die_last   = cur_reg | die_mask;
    burst_last = cur_reg | burst_mask;
    seg_end    = req_end_reg;
    if (die_last < seg_end)   seg_end = die_last;
    if (burst_last < seg_end) seg_end = burst_last;
  end

  assign req_ready   = (state_reg == IDLE);
  assign accept      = req_valid & req_ready;
  assign illegal     = (req_end < req_start) || (req_mode == 2'b11);
  assign engine_idle = !busy && !completed;
  assign gap_done    = engine_idle && ((gap_cnt_reg + 32'd1) >= GAP_LIMIT);
  assign timed_out   = (wait_cnt_reg >= TIMEOUT_LAST);
  // End detection by equality keeps req_end=0xFFFF_FFFF safe from wrap.
  assign last_seg    = (end_addr_reg == req_end_reg);

  always_ff @(posedge iCLK_25M_CKMNG_MAIN_PLD) begin
    if (!PWRGD_P1V2_MAX10_AUX_PLD_R) state_reg <= IDLE;
    else                             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (accept && !illegal) state_next = CALC;
      CALC:      state_next = ISSUE;
      ISSUE:     state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (completed)      state_next = GAP;
        else if (timed_out) state_next = IDLE;
      end
      GAP:       if (gap_done) state_next = last_seg ? DONE : CALC;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK_25M_CKMNG_MAIN_PLD) begin
    if (!PWRGD_P1V2_MAX10_AUX_PLD_R) begin
      cur_reg        <= '0;
      req_end_reg    <= '0;
      req_mode_reg   <= '0;
      cur_die_reg    <= '0;
      sw_pending_reg <= 1'b0;
      start_addr_reg <= '0;
      end_addr_reg   <= '0;
      mode_reg       <= '0;
      start_flag_reg <= 1'b0;
      switch_reg     <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      seg_count_reg  <= '0;
      wait_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      done_reg <= (state_reg == GAP) && gap_done && last_seg;
      err_reg  <= ((state_reg == IDLE) && accept && illegal) ||
                  ((state_reg == WAIT_DONE) && !completed && timed_out);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cur_reg       <= req_start;
            req_end_reg   <= req_end;
            req_mode_reg  <= req_mode;
            seg_count_reg <= '0;
          end
        end
        CALC: begin
          start_addr_reg <= cur_reg;
          end_addr_reg   <= seg_end;
          mode_reg       <= req_mode_reg;
          sw_pending_reg <= (cur_reg[31:DIE_LOG2] != cur_die_reg);
        end
        ISSUE: begin
          start_flag_reg <= 1'b1;
          switch_reg     <= sw_pending_reg;
          seg_count_reg  <= seg_count_reg + 16'd1;
          cur_die_reg    <= start_addr_reg[31:DIE_LOG2];
          wait_cnt_reg   <= '0;
          gap_cnt_reg    <= '0;
        end
        WAIT_DONE: begin
          if (completed || timed_out) begin
            start_flag_reg <= 1'b0;
            switch_reg     <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        GAP: begin
          // The idle count restarts whenever the engine shows activity.
          if (!engine_idle) begin
            gap_cnt_reg <= '0;
          end else if (gap_done) begin
            gap_cnt_reg <= '0;
            if (!last_seg) cur_reg <= end_addr_reg + 32'd1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_flag      = start_flag_reg;
  assign start_addr      = start_addr_reg;
  assign end_addr        = end_addr_reg;
  assign mode            = mode_reg;
  assign switch_die_need = switch_reg;
  assign done            = done_reg;
  assign err             = err_reg;
  assign seg_count       = seg_count_reg;

endmodule

// File: tb/tb_spi_read_segmenter.sv
// tb_spi_read_segmenter
//   Drives directed and random read requests into spi_read_segmenter, models
//   the flash engine (random latency, random busy tail, optional hang) and
//   compares every issued segment against a transaction-level model.
module tb_spi_read_segmenter;

  localparam int DIE_LOG2   = 25;
  localparam int MAX_BURST  = 256;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_start = '0;
  logic [31:0] req_end = '0;
  logic [1:0]  req_mode = '0;
  logic        start_flag;
  logic [31:0] start_addr, end_addr;
  logic [1:0]  mode;
  logic        switch_die_need;
  logic        busy = 1'b0;
  logic        completed = 1'b0;
  logic        done, err;
  logic [15:0] seg_count;

  always #20 clk = ~clk;

  spi_read_segmenter #(
    .DIE_LOG2(DIE_LOG2), .MAX_BURST(MAX_BURST),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .iCLK_25M_CKMNG_MAIN_PLD(clk),
    .PWRGD_P1V2_MAX10_AUX_PLD_R(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end), .req_mode(req_mode),
    .start_flag(start_flag), .start_addr(start_addr), .end_addr(end_addr),
    .mode(mode), .switch_die_need(switch_die_need),
    .busy(busy), .completed(completed),
    .done(done), .err(err), .seg_count(seg_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [1:0]  m;
    logic        sw;
  } seg_t;

  seg_t exp_q[$];
  longint model_die = 0;

  function automatic longint seg_end_of(input longint c, input longint e);
    longint die_end, brst_end, r;
    die_end  = ((c / (longint'(1) << DIE_LOG2)) + 1) * (longint'(1) << DIE_LOG2) - 1;
    brst_end = ((c / MAX_BURST) + 1) * MAX_BURST - 1;
    r = e;
    if (die_end < r)  r = die_end;
    if (brst_end < r) r = brst_end;
    return r;
  endfunction

  task automatic plan(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                      input bit only_first, output int n);
    longint c, se, d;
    seg_t sg;
    c = s;
    n = 0;
    forever begin
      se = seg_end_of(c, e);
      d  = c / (longint'(1) << DIE_LOG2);
      sg.s = c[31:0]; sg.e = se[31:0]; sg.m = m; sg.sw = (d != model_die);
      exp_q.push_back(sg);
      model_die = d;
      n++;
      if (se == longint'(e) || only_first) break;
      c = se + 1;
    end
  endtask

  // ---------------- engine model ----------------
  bit hang = 1'b0;
  bit in_rst = 1'b1;
  int last_tail = 0;

  initial begin
    int ecnt, tail_left, lat;
    ecnt = 0; tail_left = 0; lat = 3;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 1'b0; completed = 1'b0; ecnt = 0; tail_left = 0;
      end else if (start_flag) begin
        busy = 1'b1;
        ecnt++;
        if (!hang && ecnt >= lat) completed = 1'b1;
      end else begin
        completed = 1'b0;
        if (ecnt != 0) begin
          ecnt = 0;
          tail_left = $urandom_range(0, 3);
          last_tail = tail_left;
          lat = $urandom_range(1, 12);
        end
        if (tail_left > 0) begin
          busy = 1'b1;
          tail_left--;
        end else begin
          busy = 1'b0;
        end
      end
    end
  end

  // ---------------- segment monitor ----------------
  int issued_total = 0;
  int req_base = 0;
  int accept_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;

  initial begin
    logic prev_sf;
    seg_t cur_seg;
    prev_sf = 1'b0;
    cur_seg = '{s: '0, e: '0, m: '0, sw: 1'b0};
    forever begin
      @(negedge clk);
      if (in_rst) begin
        prev_sf = 1'b0;
      end else begin
        if (start_flag && !prev_sf) begin
          chk("seg_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) cur_seg = exp_q.pop_front();
          if (issued_total == req_base)
            chk("accept_to_start_latency", cyc - accept_cyc, 2);
          else
            chk("inter_segment_gap", cyc - fall_cyc, last_tail + GAP_CYCLES + 2);
          issued_total++;
          rise_cyc = cyc;
          chk("seg_count_at_issue", seg_count, issued_total - req_base);
        end
        if (start_flag) begin
          chk("start_addr", start_addr, cur_seg.s);
          chk("end_addr", end_addr, cur_seg.e);
          chk("mode", mode, cur_seg.m);
          chk("switch_die_need", switch_die_need, cur_seg.sw);
        end else begin
          chk("switch_die_need_idle", switch_die_need, 1'b0);
        end
        if (!start_flag && prev_sf) fall_cyc = cyc;
        prev_sf = start_flag;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_req(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                          input bit h, output int n, output bit exp_err);
    int k;
    exp_err = (e < s) || (m == 2'b11);
    n = 0;
    if (!exp_err) plan(s, e, m, h, n);
    hang = h;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_request", req_ready, 1'b1);
    req_valid = 1'b1; req_start = s; req_end = e; req_mode = m;
    @(negedge clk);
    req_valid = 1'b0;
    accept_cyc = cyc;
    req_base = issued_total;
  endtask

  task automatic run_req(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                         input bit h, output int n);
    bit exp_err;
    int k;
    send_req(s, e, m, h, n, exp_err);
    for (k = 0; k < 4000; k++) begin
      if (done || err) break;
      // Stray requests while a segment is in flight must be ignored.
      if (start_flag && !h && $urandom_range(0, 3) == 0) begin
        req_valid = 1'b1; req_start = $urandom; req_end = $urandom; req_mode = 2'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("done_pulse", done, !exp_err && !h);
    chk("err_pulse", err, exp_err || h);
    if (h && !exp_err) begin
      chk("timeout_cycles", cyc - rise_cyc, TIMEOUT);
      chk("timeout_start_flag_low", start_flag, 1'b0);
    end
    chk("seg_count_final", seg_count, n);
    chk("segments_left", exp_q.size(), 0);
    @(negedge clk);
    chk("pulses_one_cycle", {done, err}, 2'b00);
    chk("ready_after_request", req_ready, 1'b1);
    $display("[TB] req 0x%08h..0x%08h mode %0d hang %0d -> %0d segment(s)", s, e, m, h, n);
  endtask

  initial begin
    int n;
    bit ee;
    logic [31:0] s, e;
    logic [63:0] e64;
    logic [1:0] m;
    bit h;
    int sel;

    // model pins (hand-computed)
    chk("model_pin_small", seg_end_of(64'h0, 64'hF), 64'hF);
    chk("model_pin_burst", seg_end_of(64'h100, 64'h2FF), 64'h1FF);
    chk("model_pin_die", seg_end_of(64'h01FF_FFF0, 64'h0200_0010), 64'h01FF_FFFF);
    chk("model_pin_top", seg_end_of(64'hFFFF_FF80, 64'hFFFF_FFFF), 64'hFFFF_FFFF);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_outputs", {start_flag, switch_die_need, done, err, mode}, 6'b0);
    chk("rst_addrs", {start_addr, end_addr}, 64'h0);
    chk("rst_seg_count", seg_count, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    in_rst = 1'b0;

    run_req(32'h0000_0000, 32'h0000_000F, 2'b00, 1'b0, n);
    chk("tc1_nseg", n, 1);
    run_req(32'h0000_0100, 32'h0000_02FF, 2'b10, 1'b0, n);
    chk("tc2_nseg", n, 2);
    run_req(32'h01FF_FFF0, 32'h0200_0010, 2'b00, 1'b0, n);
    chk("tc3_nseg", n, 2);
    run_req(32'h0000_0020, 32'h0000_0010, 2'b00, 1'b0, n);
    run_req(32'h0000_0000, 32'h0000_000F, 2'b11, 1'b0, n);
    run_req(32'h0000_0040, 32'h0000_007F, 2'b01, 1'b1, n);
    run_req(32'hFFFF_FE80, 32'hFFFF_FFFF, 2'b10, 1'b0, n);
    chk("tc_top_nseg", n, 2);

    // reset while waiting on the engine
    send_req(32'h0000_0400, 32'h0000_04FF, 2'b00, 1'b1, n, ee);
    for (int k = 0; k < 50 && !start_flag; k++) @(negedge clk);
    chk("rst_test_started", start_flag, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    in_rst = 1'b1;
    @(negedge clk);
    chk("midrst_start_flag", start_flag, 1'b0);
    chk("midrst_no_pulse", {done, err}, 2'b00);
    chk("midrst_seg_count", seg_count, 16'h0);
    @(negedge clk);
    exp_q.delete();
    model_die = 0;
    hang = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    in_rst = 1'b0;
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_no_done_after", done, 1'b0);
    run_req(32'h0200_0000, 32'h0200_0123, 2'b01, 1'b0, n);

    // random requests
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      s = (32'($urandom_range(1, 127)) << DIE_LOG2) - 32'($urandom_range(1, 600));
      else if (sel < 6) s = 32'hFFFF_FFFF - 32'($urandom_range(0, 700));
      else              s = $urandom;
      e64 = 64'(s) + 64'($urandom_range(0, 1100));
      e = (e64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : e64[31:0];
      m = 2'($urandom_range(0, 2));
      if (sel == 9 && $urandom_range(0, 1) == 1) m = 2'b11;
      if (sel == 8 && s != 32'h0) e = s - 32'd1;
      h = ($urandom_range(0, 14) == 0);
      run_req(s, e, m, h, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
